// File: rtl/vga_timing_gen_if.sv
// Mode/raster bundle between the CPU-side mode registers, the timing generator
// and the display controller downstream.
interface vga_timing_gen_if #(
  parameter int FW = 13,
  parameter int LW = 11,
  parameter int AW = 24
);
  logic          i_pixen;
  logic [FW-1:0] i_hm_width;
  logic [FW-1:0] i_hm_porch;
  logic [FW-1:0] i_hm_synch;
  logic [FW-1:0] i_hm_raw;
  logic [LW-1:0] i_vm_height;
  logic [LW-1:0] i_vm_porch;
  logic [LW-1:0] i_vm_synch;
  logic [LW-1:0] i_vm_raw;
  logic [AW-1:0] i_base;
  logic          i_int_ack;
  logic          o_hsync;
  logic          o_vsync;
  logic          o_blank;
  logic [FW-1:0] o_x;
  logic [LW-1:0] o_y;
  logic [AW-1:0] o_addr;
  logic          o_newframe;
  logic          o_interrupt;
  logic          o_mode_err;

  modport master (
    output i_pixen, i_hm_width, i_hm_porch, i_hm_synch, i_hm_raw,
    output i_vm_height, i_vm_porch, i_vm_synch, i_vm_raw, i_base, i_int_ack,
    input  o_hsync, o_vsync, o_blank, o_x, o_y, o_addr,
    input  o_newframe, o_interrupt, o_mode_err
  );

  modport slave (
    input  i_pixen, i_hm_width, i_hm_porch, i_hm_synch, i_hm_raw,
    input  i_vm_height, i_vm_porch, i_vm_synch, i_vm_raw, i_base, i_int_ack,
    output o_hsync, o_vsync, o_blank, o_x, o_y, o_addr,
    output o_newframe, o_interrupt, o_mode_err
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters, sync/blank decode, linear
// video-RAM address and vertical-blank interrupt, with frame-shadowed mode.
module vga_timing_gen #(
  parameter int   FW        = 13,
  parameter int   LW        = 11,
  parameter int   AW        = 24,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  vga_timing_gen_if.slave bus
);

  localparam logic [0:0] S_LOAD = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]    r_state;
  logic [FW-1:0] r_h;
  logic [LW-1:0] r_v;
  logic [AW-1:0] r_line_base;
  logic [AW-1:0] r_addr;
  logic          r_hsync;
  logic          r_vsync;
  logic          r_blank;
  logic          r_newframe;
  logic          r_interrupt;
  logic          r_mode_err;

  logic [FW-1:0] r_hw, r_hp, r_hs, r_hr;
  logic [LW-1:0] r_vh, r_vp, r_vs, r_vr;
  logic [AW-1:0] r_base;

  logic          w_in_valid;
  logic [FW-1:0] w_hw, w_hp, w_hs;
  logic [LW-1:0] w_vh, w_vp, w_vs;
  logic          w_h_end;
  logic          w_v_end;
  logic [0:0]    w_state_n;
  logic [FW-1:0] w_h_n;
  logic [LW-1:0] w_v_n;
  logic [AW-1:0] w_lb_n;
  logic          w_err_n;
  logic          w_nf_n;
  logic          w_irq_set;
  logic          w_hs_act;
  logic          w_vs_act;
  logic          w_blank_n;

  assign w_in_valid = (bus.i_hm_width  > FW'(16))         &&
                      (bus.i_hm_width  < bus.i_hm_porch)  &&
                      (bus.i_hm_porch  < bus.i_hm_synch)  &&
                      (bus.i_hm_synch  < bus.i_hm_raw)    &&
                      (bus.i_vm_height > LW'(16))         &&
                      (bus.i_vm_height < bus.i_vm_porch)  &&
                      (bus.i_vm_porch  < bus.i_vm_synch)  &&
                      (bus.i_vm_synch  < bus.i_vm_raw);

  // In LOAD the pixel being emitted is decoded from the mode being sampled now
  assign w_hw = (r_state == S_LOAD) ? bus.i_hm_width  : r_hw;
  assign w_hp = (r_state == S_LOAD) ? bus.i_hm_porch  : r_hp;
  assign w_hs = (r_state == S_LOAD) ? bus.i_hm_synch  : r_hs;
  assign w_vh = (r_state == S_LOAD) ? bus.i_vm_height : r_vh;
  assign w_vp = (r_state == S_LOAD) ? bus.i_vm_porch  : r_vp;
  assign w_vs = (r_state == S_LOAD) ? bus.i_vm_synch  : r_vs;

  assign w_h_end = (r_h == (r_hr - FW'(1)));
  assign w_v_end = (r_v == (r_vr - LW'(1)));

  always_comb begin
    w_state_n = r_state;
    w_h_n     = r_h;
    w_v_n     = r_v;
    w_lb_n    = r_line_base;
    w_err_n   = r_mode_err;
    w_nf_n    = 1'b0;
    w_irq_set = 1'b0;
    if (r_state == S_LOAD) begin
      w_h_n   = '0;
      w_v_n   = '0;
      w_lb_n  = bus.i_base;
      w_err_n = ~w_in_valid;
      if (w_in_valid) begin
        w_state_n = S_RUN;
      end
    end else if (w_h_end) begin
      w_h_n = '0;
      if (w_v_end) begin
        w_v_n     = '0;
        w_state_n = S_LOAD;
        w_lb_n    = r_base;
        w_nf_n    = 1'b1;
      end else begin
        w_v_n = r_v + LW'(1);
        // Below the active area the line base stops advancing
        if (r_v < r_vh) begin
          w_lb_n = r_line_base + AW'(r_hw);
        end
        w_irq_set = (w_v_n == r_vh);
      end
    end else begin
      w_h_n = r_h + FW'(1);
    end
  end

  assign w_hs_act  = (w_state_n == S_RUN) && (w_h_n >= w_hp) && (w_h_n < w_hs);
  assign w_vs_act  = (w_state_n == S_RUN) && (w_v_n >= w_vp) && (w_v_n < w_vs);
  assign w_blank_n = (w_state_n == S_LOAD) || (w_h_n >= w_hw) || (w_v_n >= w_vh);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= S_LOAD;
      r_h         <= '0;
      r_v         <= '0;
      r_line_base <= '0;
      r_addr      <= '0;
      r_hsync     <= ~HSYNC_POL;
      r_vsync     <= ~VSYNC_POL;
      r_blank     <= 1'b1;
      r_newframe  <= 1'b0;
      r_interrupt <= 1'b0;
      r_mode_err  <= 1'b0;
    end else begin
      r_newframe <= bus.i_pixen & w_nf_n;
      if (bus.i_pixen && w_irq_set) begin
        r_interrupt <= 1'b1;
      end else if (bus.i_int_ack) begin
        r_interrupt <= 1'b0;
      end
      if (bus.i_pixen) begin
        r_state     <= w_state_n;
        r_h         <= w_h_n;
        r_v         <= w_v_n;
        r_line_base <= w_lb_n;
        r_addr      <= w_lb_n + AW'(w_h_n);
        r_hsync     <= w_hs_act ? HSYNC_POL : ~HSYNC_POL;
        r_vsync     <= w_vs_act ? VSYNC_POL : ~VSYNC_POL;
        r_blank     <= w_blank_n;
        r_mode_err  <= w_err_n;
      end
    end
  end

  // Shadow copy follows the inputs throughout LOAD and freezes for the frame
  always_ff @(posedge i_clk) begin
    if (r_state == S_LOAD) begin
      r_hw   <= bus.i_hm_width;
      r_hp   <= bus.i_hm_porch;
      r_hs   <= bus.i_hm_synch;
      r_hr   <= bus.i_hm_raw;
      r_vh   <= bus.i_vm_height;
      r_vp   <= bus.i_vm_porch;
      r_vs   <= bus.i_vm_synch;
      r_vr   <= bus.i_vm_raw;
      r_base <= bus.i_base;
    end
  end

  assign bus.o_hsync     = r_hsync;
  assign bus.o_vsync     = r_vsync;
  assign bus.o_blank     = r_blank;
  assign bus.o_x         = r_h;
  assign bus.o_y         = r_v;
  assign bus.o_addr      = r_addr;
  assign bus.o_newframe  = r_newframe;
  assign bus.o_interrupt = r_interrupt;
  assign bus.o_mode_err  = r_mode_err;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a reduced 40/44/52/60 x 20/21/25/28 mode.
module tb_vga_timing_gen;
  localparam int FW = 13;
  localparam int LW = 11;
  localparam int AW = 24;
  localparam logic [63:0] RESET_VEC = {10'd0, 3'b111, 13'd0, 11'd0, 24'd0, 3'b000};

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  vga_timing_gen_if #(.FW(FW), .LW(LW), .AW(AW)) bus();

  vga_timing_gen #(.FW(FW), .LW(LW), .AW(AW), .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model state
  bit m_run, m_err, m_nf, m_irq;
  int m_h, m_v, m_w, m_p, m_s, m_r, m_vh, m_vp, m_vs, m_vr;
  logic [AW-1:0] m_base;
  logic [63:0] exp_q[$];

  int  cyc = 0;
  int  pix_div = 1;
  bit  addr_chk_en = 0;
  int  st_clk, st_blo, st_hs, st_vs;

  task automatic model_reset();
    m_run = 0; m_err = 0; m_nf = 0; m_irq = 0;
    m_h = 0; m_v = 0; m_base = '0;
    m_w = 0; m_p = 0; m_s = 0; m_r = 0; m_vh = 0; m_vp = 0; m_vs = 0; m_vr = 0;
  endtask

  function automatic bit mode_ok();
    return (16 < int'(bus.i_hm_width)) && (bus.i_hm_width < bus.i_hm_porch) &&
           (bus.i_hm_porch < bus.i_hm_synch) && (bus.i_hm_synch < bus.i_hm_raw) &&
           (16 < int'(bus.i_vm_height)) && (bus.i_vm_height < bus.i_vm_porch) &&
           (bus.i_vm_porch < bus.i_vm_synch) && (bus.i_vm_synch < bus.i_vm_raw);
  endfunction

  task automatic model_step();
    bit set;
    set = 0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_nf = 0;
    if (!m_run) begin
      if (bus.i_pixen) begin
        m_w = int'(bus.i_hm_width);  m_p = int'(bus.i_hm_porch);
        m_s = int'(bus.i_hm_synch);  m_r = int'(bus.i_hm_raw);
        m_vh = int'(bus.i_vm_height); m_vp = int'(bus.i_vm_porch);
        m_vs = int'(bus.i_vm_synch);  m_vr = int'(bus.i_vm_raw);
        m_base = bus.i_base;
        m_h = 0; m_v = 0;
        if (mode_ok()) begin m_run = 1; m_err = 0; end
        else m_err = 1;
      end
    end else if (bus.i_pixen) begin
      if (m_h == m_r - 1) begin
        m_h = 0;
        if (m_v == m_vr - 1) begin m_v = 0; m_run = 0; m_nf = 1; end
        else begin m_v++; if (m_v == m_vh) set = 1; end
      end else m_h++;
    end
    if (set) m_irq = 1;
    else if (bus.i_int_ack) m_irq = 0;
  endtask

  function automatic logic [63:0] model_out();
    bit hs, vs, bl;
    int vv;
    longint a;
    logic [AW-1:0] al;
    hs = m_run && (m_h >= m_p) && (m_h < m_s);
    vs = m_run && (m_v >= m_vp) && (m_v < m_vs);
    bl = !m_run || (m_h >= m_w) || (m_v >= m_vh);
    vv = (m_v < m_vh) ? m_v : m_vh;
    a  = longint'(m_base) + longint'(vv) * longint'(m_w) + longint'(m_h);
    al = a[AW-1:0];
    return {10'd0, ~hs, ~vs, bl, FW'(m_h), LW'(m_v), al, m_nf, m_irq, m_err};
  endfunction

  function automatic logic [63:0] observed();
    return {10'd0, bus.o_hsync, bus.o_vsync, bus.o_blank, bus.o_x, bus.o_y, bus.o_addr,
            bus.o_newframe, bus.o_interrupt, bus.o_mode_err};
  endfunction

  task automatic tick();
    bus.i_pixen = ((cyc % pix_div) == 0);
    cyc++;
    model_step();
    exp_q.push_back(model_out());
    @(posedge clk);
    #1;
    check("cyc", observed(), exp_q.pop_front());
    st_clk++;
    if (!bus.o_blank) st_blo++;
    if (bus.o_hsync == 1'b0) st_hs++;
    if (bus.o_vsync == 1'b0) st_vs++;
    if (addr_chk_en && !bus.o_blank) begin
      if (bus.o_x == 0 && bus.o_y == 0) check("addr00", 64'(bus.o_addr), 64'h010000);
      if (bus.o_x == 0 && bus.o_y == 1) check("addr01", 64'(bus.o_addr), 64'h010028);
      if (bus.o_x == 39 && bus.o_y == 19)
        check("addr_last", 64'(bus.o_addr), 64'h010000 + 64'd39 + 64'd19 * 64'd40);
    end
    @(negedge clk);
  endtask

  task automatic st_clear();
    st_clk = 0; st_blo = 0; st_hs = 0; st_vs = 0;
  endtask

  task automatic run_to_nf(input int limit);
    bit ok;
    ok = 0;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (bus.o_newframe) begin ok = 1; break; end
    end
    check("nf_seen", 64'(ok), 64'd1);
  endtask

  task automatic set_mode(input int w, input int p, input int s, input int r,
                          input int vh, input int vp, input int vs, input int vr);
    bus.i_hm_width  = FW'(w);  bus.i_hm_porch = FW'(p);
    bus.i_hm_synch  = FW'(s);  bus.i_hm_raw   = FW'(r);
    bus.i_vm_height = LW'(vh); bus.i_vm_porch = LW'(vp);
    bus.i_vm_synch  = LW'(vs); bus.i_vm_raw   = LW'(vr);
  endtask

  initial begin
    bit found;
    bus.i_pixen = 1'b0;
    bus.i_int_ack = 1'b0;
    bus.i_base = 24'h010000;
    set_mode(40, 44, 52, 60, 20, 21, 25, 28);
    model_reset();
    st_clear();

    #2 rst_n = 1'b0;
    #1 check("reset_vals", observed(), RESET_VEC);
    @(negedge clk);
    tick();
    tick();
    rst_n = 1'b1;

    addr_chk_en = 1;
    run_to_nf(5000);
    st_clear();
    run_to_nf(3000);
    check("period", 64'(st_clk), 64'd1681);
    check("blank_lo", 64'(st_blo), 64'd800);
    check("hsync_act", 64'(st_hs), 64'd224);
    check("vsync_act", 64'(st_vs), 64'd240);
    addr_chk_en = 0;

    // Width rewritten mid-frame
    st_clear();
    for (int i = 0; i < 500; i++) tick();
    bus.i_hm_width = FW'(36);
    run_to_nf(3000);
    check("old_width", 64'(st_blo), 64'd800);
    st_clear();
    run_to_nf(3000);
    check("new_width", 64'(st_blo), 64'd720);
    bus.i_hm_width = FW'(40);

    // Interrupt set/ack priority
    bus.i_int_ack = 1'b1;
    tick();
    bus.i_int_ack = 1'b0;
    check("irq_clr", 64'(bus.o_interrupt), 64'd0);
    found = 0;
    for (int i = 0; i < 3000; i++) begin
      if (m_run && m_h == m_r - 1 && m_v == m_vh - 1) begin found = 1; break; end
      tick();
    end
    check("irq_pos", 64'(found), 64'd1);
    bus.i_int_ack = 1'b1;
    tick();
    check("irq_set_wins", 64'(bus.o_interrupt), 64'd1);
    tick();
    check("irq_ack", 64'(bus.o_interrupt), 64'd0);
    bus.i_int_ack = 1'b0;

    // Invalid mode, then fix
    bus.i_hm_width = FW'(44);
    run_to_nf(3000);
    for (int i = 0; i < 10; i++) tick();
    check("err_set", 64'(bus.o_mode_err), 64'd1);
    check("err_blank", 64'(bus.o_blank), 64'd1);
    check("err_xy", {bus.o_x, bus.o_y}, 64'd0);
    bus.i_hm_width = FW'(40);
    tick();
    tick();
    check("fix_err", 64'(bus.o_mode_err), 64'd0);
    check("fix_x", 64'(bus.o_x), 64'd1);

    // 1-in-4 pixel enable with reset mid-frame
    pix_div = 4;
    found = 0;
    for (int i = 0; i < 12000; i++) begin
      if (m_run && m_h == 30 && m_v == 10) begin found = 1; break; end
      tick();
    end
    check("rst_pos", 64'(found), 64'd1);
    rst_n = 1'b0;
    #1 check("rst_mid", observed(), RESET_VEC);
    model_reset();
    @(negedge clk);
    tick();
    tick();
    rst_n = 1'b1;
    run_to_nf(8000);
    st_clear();
    run_to_nf(8000);
    check("period_div4", 64'(st_clk), 64'd6724);
    check("blank_lo_div4", 64'(st_blo), 64'd3200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
